// File: rtl/imem_pkg.sv
// Shared constants and helpers for the instruction-memory AXI4-Lite responder.
package imem_pkg;

  localparam logic [31:0] IMEM_NOP       = 32'h0000_0013;
  localparam logic [31:0] IMEM_ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] IMEM_IRAM_BASE = 32'h0010_0000;

  function automatic int unsigned imem_idx_width(input int unsigned depth_words);
    return (depth_words < 2) ? 1 : $clog2(depth_words);
  endfunction

endpackage

// File: rtl/axi_imem_responder_if.sv
// AXI4-Lite read-only channel (AR + R) between a fetch master and the imem responder.
interface axi_imem_responder_if;

  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        s_rready;

  modport master (
    output s_araddr,
    output s_arvalid,
    input  s_arready,
    input  s_rdata,
    input  s_rvalid,
    output s_rready
  );

  modport slave (
    input  s_araddr,
    input  s_arvalid,
    output s_arready,
    output s_rdata,
    output s_rvalid,
    input  s_rready
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Small synchronous response FIFO; head reads as zero when empty.
module imem_rsp_fifo #(
  parameter  int unsigned Depth = 3,
  parameter  int unsigned Width = 32,
  localparam int unsigned CW    = $clog2(Depth + 1),
  localparam int unsigned PW    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic [CW-1:0]    count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/axi_imem_responder.sv
// AXI4-Lite read-only responder in front of a synchronous instruction SRAM/ROM.
// Optional build macro IMEM_RANGE_CHECK_EN: out-of-range fetches return a NOP without an SRAM read.
module axi_imem_responder
  import imem_pkg::*;
#(
  parameter  logic [31:0] BASE_ADDR   = IMEM_IRAM_BASE,
  parameter  int unsigned DEPTH_WORDS = 4096,
  parameter  int unsigned RSP_DEPTH   = 3,
  localparam int unsigned AW          = imem_idx_width(DEPTH_WORDS),
  localparam int unsigned CW          = $clog2(RSP_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_imem_responder_if.slave  s,
  output logic                 mem_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [31:0]          mem_rdata
);

  logic          acc;
  logic          in_range;
  logic          inflight_q;
  logic          pop;
  logic [31:0]   push_data;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;

  // Every accepted address reserves a slot until popped, so a push never overflows.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign s.s_arready = credit_used < (CW + 1)'(RSP_DEPTH);

  assign acc      = s.s_arvalid & s.s_arready;
  assign mem_en   = acc & in_range;
  assign mem_addr = s.s_araddr[2 +: AW];

`ifdef IMEM_RANGE_CHECK_EN
  logic [32:0] range_end;
  logic        oor_q;

  assign range_end = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  assign in_range  = (s.s_araddr >= BASE_ADDR) && ({1'b0, s.s_araddr} < range_end) &&
                     (s.s_araddr[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= acc & ~in_range;
    end
  end

  assign push_data = oor_q ? IMEM_NOP : mem_rdata;
`else
  logic unused_addr_bits;

  // Upper and byte-offset bits are ignored; accesses alias modulo the memory size.
  assign unused_addr_bits = ^{s.s_araddr[31:2+AW], s.s_araddr[1:0]};
  assign in_range         = 1'b1;
  assign push_data        = mem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= acc;
    end
  end

  assign s.s_rvalid = (count != '0);
  assign pop        = s.s_rvalid & s.s_rready;

  imem_rsp_fifo #(
    .Depth (RSP_DEPTH),
    .Width (32)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (s.s_rdata),
    .count     (count)
  );

endmodule

// File: tb/tb_axi_imem_responder.sv
// Self-checking bench: table-driven fetches, corner sequences and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_axi_imem_responder;
  import imem_pkg::*;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int unsigned DW   = 4096;
  localparam int unsigned RD   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] sram [DW];

  axi_imem_responder_if bus();

  axi_imem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DW),
    .RSP_DEPTH   (RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (bus.slave),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= sram[mem_addr];
  end

  typedef struct {
    logic [31:0] word;
    int          edge_no;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic        en;
  } vec_t;

  exp_t exp_q[$];
  int   beat_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[7];

  function automatic logic ref_en(input logic [31:0] a);
`ifdef IMEM_RANGE_CHECK_EN
    if (a < BASE || (a - BASE) >= 4 * DW || a[1:0] != 2'b00) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (!ref_en(a)) return IMEM_NOP;
    return sram[(a >> 2) % DW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic valid, input logic ready);
    bus.s_araddr  = addr;
    bus.s_arvalid = valid;
    bus.s_rready  = ready;
  endtask

  // One clock: model check at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic exp_ar, exp_rv, acc;
    @(negedge clk);
    if (rst_n) begin
      exp_ar = exp_q.size() < RD;
      exp_rv = (exp_q.size() > 0) && (exp_q[0].edge_no + 1 <= cyc);
      check("arready", 32'(bus.s_arready), 32'(exp_ar));
      check("rvalid", 32'(bus.s_rvalid), 32'(exp_rv));
      check("rdata", bus.s_rdata, exp_rv ? exp_q[0].word : 32'h0);
      acc = bus.s_arvalid && exp_ar;
      check("mem_en", 32'(mem_en), 32'(acc && ref_en(bus.s_araddr)));
      if (acc && ref_en(bus.s_araddr))
        check("mem_addr", 32'(mem_addr), (bus.s_araddr >> 2) % DW);
      if (exp_rv && bus.s_rready) begin
        void'(exp_q.pop_front());
        beat_cyc.push_back(cyc);
      end
      if (acc) exp_q.push_back('{ref_word(bus.s_araddr), cyc + 1});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic single_fetch(input vec_t v);
    drive(v.addr, 1'b1, 1'b1);
    #1;
    check("vec_mem_en", 32'(mem_en), 32'(v.en));
    tick();
    drive(32'h0, 1'b0, 1'b1);
    check("vec_rvalid_T1", 32'(bus.s_rvalid), 32'h0);
    tick();
    check("vec_rvalid_T2", 32'(bus.s_rvalid), 32'h1);
    check("vec_rdata", bus.s_rdata, v.word);
    tick();
    check("vec_one_beat", 32'(bus.s_rvalid), 32'h0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    drive(32'h0, 1'b0, 1'b1);
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    int acc_cnt;
    logic [31:0] held;
    for (int i = 0; i < int'(DW); i++) sram[i] = 32'(i) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    sram[2] = 32'hDEAD_BEEF;

    vecs[0] = '{32'h0010_0008, 32'hDEAD_BEEF, 1'b1};
    vecs[1] = '{32'h0010_0000, sram[0], 1'b1};
    vecs[2] = '{32'h0010_3FFC, sram[4095], 1'b1};
`ifdef IMEM_RANGE_CHECK_EN
    vecs[3] = '{32'h0020_0000, IMEM_NOP, 1'b0};
    vecs[4] = '{32'h000F_FFFC, IMEM_NOP, 1'b0};
    vecs[5] = '{32'h0010_0006, IMEM_NOP, 1'b0};
    vecs[6] = '{32'h0010_4000, IMEM_NOP, 1'b0};
`else
    vecs[3] = '{32'h0020_0000, sram[0], 1'b1};
    vecs[4] = '{32'h000F_FFFC, sram[4095], 1'b1};
    vecs[5] = '{32'h0010_0006, sram[1], 1'b1};
    vecs[6] = '{32'h0010_4000, sram[0], 1'b1};
`endif

    drive(32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_arready", 32'(bus.s_arready), 32'h1);
    check("rst_rvalid", 32'(bus.s_rvalid), 32'h0);
    check("rst_rdata", bus.s_rdata, 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) single_fetch(vecs[i]);

    // Streaming: 8 back-to-back fetches, beats on consecutive cycles.
    beat_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      drive(BASE + 32'(4 * i), 1'b1, 1'b1);
      #1;
      check("stream_arready", 32'(bus.s_arready), 32'h1);
      tick();
    end
    drain(10);
    check("stream_beats", 32'(beat_cyc.size()), 32'd8);
    for (int i = 1; i < beat_cyc.size(); i++)
      check("stream_gap", 32'(beat_cyc[i] - beat_cyc[0]), 32'(i));

    // Backpressure: exactly RD accepts, head stays stable.
    beat_cyc.delete();
    acc_cnt = 0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      drive(BASE + 32'h40 + 32'(4 * i), 1'b1, 1'b0);
      #1;
      if (bus.s_arready) acc_cnt++;
      if (i == 3) held = bus.s_rdata;
      if (i > 3) check("bp_rdata_stable", bus.s_rdata, held);
      tick();
    end
    check("bp_accepts", 32'(acc_cnt), 32'(RD));
    check("bp_arready_low", 32'(bus.s_arready), 32'h0);
    check("bp_head", bus.s_rdata, sram[16]);
    drain(8);
    check("bp_beats", 32'(beat_cyc.size()), 32'(RD));
    check("bp_resume", 32'(bus.s_arready), 32'h1);

    // Full buffer with a pop while the last read is still landing.
    beat_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      drive(BASE + 32'h80 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    drive(BASE + 32'h90, 1'b1, 1'b1);
    #1;
    check("full_pp_arready", 32'(bus.s_arready), 32'h0);
    check("full_pp_rvalid", 32'(bus.s_rvalid), 32'h1);
    tick();
    drive(32'h0, 1'b0, 1'b1);
    #1;
    check("full_pp_after", 32'(bus.s_arready), 32'h1);
    drain(8);
    check("full_pp_beats", 32'(beat_cyc.size()), 32'd3);

    // Reset with two buffered and one in flight.
    for (int i = 0; i < 3; i++) begin
      drive(BASE + 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    drive(32'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 32'(bus.s_rvalid), 32'h0);
    check("midrst_rdata", bus.s_rdata, 32'h0);
    check("midrst_arready", 32'(bus.s_arready), 32'h1);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    drive(32'h0, 1'b0, 1'b1);
    tick();
    tick();
    check("midrst_no_stale", 32'(bus.s_rvalid), 32'h0);
    single_fetch(vecs[0]);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) != 0) a = BASE + 32'(4 * $urandom_range(0, DW - 1));
      else a = $urandom();
      drive(a, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      tick();
    end
    drain(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
